prog_rom_mem: RTL and testbench
===============================

# prog_rom_mem

Parametrised, single-port, programmable ROM. The block is written during a programming phase and then locked read-only until the next reset. It generalises the fixed 4 KB × 8 write/read memory to configurable width and depth, and adds:
- a registered read with a valid strobe,
- a post-reset clear sweep,
- a sticky write lock,
- error strobes for rejected writes and out-of-range addresses.

It sits between the boot/programming master and the instruction/table consumers.

## Interface
Parameters:
- DATA_W, 8, word width in bits
- ADDR_W, 12, address width
- DEPTH, 1<<ADDR_W, number of implemented words; must be ≤ 2^ADDR_W
- CLEAR_VAL, 0, word value written by the clear sweep

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- write_enable  in  1  write request this cycle
- rd_en  in  1  read request this cycle
- address  in  ADDR_W  word address for read and write
- data_in  in  DATA_W  write data
- lock  in  1  single-cycle pulse; makes the memory read-only (sticky)
- data_out  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle strobe; data_out is valid
- ready  out  1  memory accepts requests
- locked  out  1  lock state
- wr_err  out  1  one-cycle strobe; write rejected because locked
- addr_err  out  1  one-cycle strobe; request address ≥ DEPTH

## Operation
- FSM states: CLEAR, PROG, LOCKED.
  - Reset → CLEAR (or PROG if clear is compiled out).
  - CLEAR → PROG after the last sweep word.
  - PROG → LOCKED on lock.
  - LOCKED exits only via rst_n.
- CLEAR:
  - A sweep counter writes CLEAR_VAL to addresses 0..DEPTH-1, one per cycle.
  - ready=0.
  - write_enable, rd_en and lock are ignored; no strobes are raised.
- PROG:
  - write_enable with address < DEPTH → mem[address] <= data_in.
  - rd_en → data_out <= mem[address] and rd_valid pulses.
- LOCKED:
  - Reads behave as in PROG.
  - Every write_enable cycle is dropped and pulses wr_err.
- Simultaneous read and write to the same address: read-first (data_out gets the old word).
- Lock asserted in the same cycle as a write in PROG: the write completes and locked=1 from the next cycle.
- Address ≥ DEPTH:
  - A write is dropped.
  - A read returns data_out=0 with rd_valid=1.
  - addr_err pulses in either case.
  - In LOCKED, an out-of-range write raises both wr_err and addr_err.
- data_out holds its last value when no read occurs.
- Memory array is not reset. Without a clear sweep, contents survive rst_n.

## Timing
- Reset values: data_out=0, rd_valid=0, ready=0, locked=0, wr_err=0, addr_err=0.
- Read latency: 1 cycle (rd_en sampled at edge N; data_out/rd_valid valid after edge N). Back-to-back reads every cycle are supported.
- Write: takes effect at the sampling edge; a read issued the following cycle returns the new data.
- Clear sweep:
  - The first edge after rst_n release writes address 0.
  - ready rises after edge DEPTH, and the first request is accepted at edge DEPTH+1.
- Without clear: ready rises after the first edge following rst_n release.
- wr_err and addr_err are registered and appear alongside the rd_valid timing (1 cycle after the request).
- rst_n low at any point (mid-sweep, mid-read, locked) immediately forces all outputs to their reset values. The sweep restarts from address 0 on release.

## Configuration
- PROG_ROM_CLEAR_EN defined: CLEAR state and sweep counter are present; memory equals CLEAR_VAL everywhere when ready rises.
- PROG_ROM_CLEAR_EN undefined: no CLEAR state or counter; reset enters PROG; array contents are untouched by reset.

## Test plan
- Reset release with PROG_ROM_CLEAR_EN defined, defaults → ready=0 for 4096 cycles, then 1; a read of 0x7FF returns 0x00 with rd_valid.
- Write 0xA5, 0x5A, 0xFF, 0x00 to addresses 0..3, then read 0..3 back to back → data_out A5, 5A, FF, 00, each one cycle after rd_en, with rd_valid high for four consecutive cycles.
- Address 5 holds 0x11; issue write 0x3C and read of 5 in the same cycle → data_out=0x11; next read of 5 → 0x3C.
- Pulse lock, then write 0x77 to address 0 → wr_err pulses one cycle, locked=1; read of 0 returns 0xA5.
- DEPTH=3000: read address 3000 → data_out=0x00, rd_valid=1, addr_err=1; write to 3000 → addr_err=1 and no array change.
- Drop rst_n at sweep cycle 100, and separately while locked → all outputs reset, locked=0; the sweep restarts and ready returns only after a full 4096 cycles. Without the macro, previously written data survives reset.

Source files
------------

// File: rtl/prog_rom_mem.sv
// Programmable single-port ROM: written during programming, then locked read-only until reset.
// Define PROG_ROM_CLEAR_EN to sweep CLEAR_VAL through the array after every reset.
module prog_rom_mem #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 12,
    parameter int unsigned       DEPTH     = 1 << ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_enable,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              lock,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              ready,
    output logic              locked,
    output logic              wr_err,
    output logic              addr_err
);

    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

`ifdef PROG_ROM_CLEAR_EN
    typedef enum logic [1:0] {StClear, StProg, StLocked} state_e;
    localparam state_e            ResetState = StClear;
    localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] sweep_q, sweep_d;
`else
    typedef enum logic [1:0] {StProg, StLocked} state_e;
    localparam state_e ResetState = StProg;
`endif

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ready_q, ready_d;
    logic              locked_q, locked_d;
    logic              wr_err_q, wr_err_d;
    logic              addr_err_q, addr_err_d;

    logic              in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign in_range = {1'b0, address} < DepthW;

    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        wr_err_d   = 1'b0;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = address;
        mem_wdata  = data_in;
`ifdef PROG_ROM_CLEAR_EN
        sweep_d    = sweep_q;
`endif
        unique case (state_q)
`ifdef PROG_ROM_CLEAR_EN
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                mem_wdata = CLEAR_VAL;
                sweep_d   = sweep_q + 1'b1;
                if (sweep_q == LastAddr) begin
                    state_d = StProg;
                end
            end
`endif
            StProg, StLocked: begin
                // Requests are ignored until the first edge after reset release has passed.
                if (ready_q) begin
                    if (rd_en) begin
                        rd_valid_d = 1'b1;
                        data_out_d = in_range ? mem[address] : '0;
                    end
                    if (write_enable) begin
                        if (state_q == StLocked) begin
                            wr_err_d = 1'b1;
                        end else if (in_range) begin
                            mem_we = 1'b1;
                        end
                    end
                    if ((write_enable || rd_en) && !in_range) begin
                        addr_err_d = 1'b1;
                    end
                    if (state_q == StProg && lock) begin
                        state_d = StLocked;
                    end
                end
            end
            default: state_d = ResetState;
        endcase
`ifdef PROG_ROM_CLEAR_EN
        ready_d  = (state_d != StClear);
`else
        ready_d  = 1'b1;
`endif
        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ResetState;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            ready_q    <= 1'b0;
            locked_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            addr_err_q <= 1'b0;
`ifdef PROG_ROM_CLEAR_EN
            sweep_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            ready_q    <= ready_d;
            locked_q   <= locked_d;
            wr_err_q   <= wr_err_d;
            addr_err_q <= addr_err_d;
`ifdef PROG_ROM_CLEAR_EN
            sweep_q    <= sweep_d;
`endif
        end
    end

    // Array has no reset; read above samples the old word, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign ready    = ready_q;
    assign locked   = locked_q;
    assign wr_err   = wr_err_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_prog_rom_mem.sv
// Self-checking bench for prog_rom_mem (DEPTH=3000) against an array-based reference model.
module tb_prog_rom_mem;

    localparam int DW    = 8;
    localparam int AW    = 12;
    localparam int DEPTH = 3000;
`ifdef PROG_ROM_CLEAR_EN
    localparam int ReadyLat = DEPTH;
`else
    localparam int ReadyLat = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          write_enable = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in = '0;
    logic          lock = 1'b0;
    logic [DW-1:0] data_out;
    logic          rd_valid, ready, locked, wr_err, addr_err;

    prog_rom_mem #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write_enable(write_enable),
        .rd_en       (rd_en),
        .address     (address),
        .data_in     (data_in),
        .lock        (lock),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .ready       (ready),
        .locked      (locked),
        .wr_err      (wr_err),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] model [DEPTH];
    bit            m_locked = 1'b0;
    logic [DW-1:0] exp_dout = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_enable = 1'b0;
        rd_en        = 1'b0;
        lock         = 1'b0;
    endtask

    // One request cycle once ready; expectations come from the array model and the lock flag.
    task automatic op(input bit we, input bit re, input int addr, input int din, input bit lk);
        bit inr;
        write_enable = we;
        rd_en        = re;
        address      = addr[AW-1:0];
        data_in      = din[DW-1:0];
        lock         = lk;
        inr          = addr < DEPTH;
        if (re) exp_dout = inr ? model[addr] : '0;
        tick();
        check("data_out", {24'd0, data_out}, {24'd0, exp_dout});
        check("rd_valid", {31'd0, rd_valid}, {31'd0, re});
        check("wr_err", {31'd0, wr_err}, {31'd0, we && m_locked});
        check("addr_err", {31'd0, addr_err}, {31'd0, (we || re) && !inr});
        if (we && !m_locked && inr) model[addr] = din[DW-1:0];
        if (lk) m_locked = 1'b1;
        check("locked", {31'd0, locked}, {31'd0, m_locked});
        check("ready", {31'd0, ready}, 32'd1);
        idle();
    endtask

    // Asserts rst_n mid-cycle, checks outputs clear at once, releases after two edges.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_wr_err", {31'd0, wr_err}, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        m_locked = 1'b0;
        exp_dout = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Hammers requests while not ready: all must be ignored; ready must rise exactly at edge n.
    task automatic wait_ready(input int n);
        write_enable = 1'b1;
        rd_en        = 1'b1;
        lock         = 1'b1;
        address      = AW'(DEPTH);
        data_in      = 8'hC3;
        for (int i = 1; i <= n; i++) begin
            tick();
            check("ready_rise", {31'd0, ready}, {31'd0, i == n});
            check("busy_rd_valid", {31'd0, rd_valid}, 32'd0);
            check("busy_addr_err", {31'd0, addr_err}, 32'd0);
            check("busy_wr_err", {31'd0, wr_err}, 32'd0);
            check("busy_locked", {31'd0, locked}, 32'd0);
        end
        idle();
    endtask

    initial begin
        #12;
        check("init_data_out", {24'd0, data_out}, 32'd0);
        check("init_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("init_ready", {31'd0, ready}, 32'd0);
        check("init_locked", {31'd0, locked}, 32'd0);
        check("init_wr_err", {31'd0, wr_err}, 32'd0);
        check("init_addr_err", {31'd0, addr_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef PROG_ROM_CLEAR_EN
        // Abort the sweep at cycle 100; the restart must take a full DEPTH cycles.
        for (int i = 1; i <= 100; i++) begin
            tick();
            check("sweep_busy", {31'd0, ready}, 32'd0);
        end
        do_reset();
        wait_ready(ReadyLat);
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        op(0, 1, 'h7FF, 0, 0);
`else
        wait_ready(ReadyLat);
        for (int a = 0; a < DEPTH; a++) op(1, 0, a, int'($urandom_range(0, 255)), 0);
`endif

        op(1, 0, 0, 'hA5, 0);
        op(1, 0, 1, 'h5A, 0);
        op(1, 0, 2, 'hFF, 0);
        op(1, 0, 3, 'h00, 0);
        for (int a = 0; a < 4; a++) op(0, 1, a, 0, 0);

        op(1, 0, 5, 'h11, 0);
        op(1, 1, 5, 'h3C, 0);
        op(0, 1, 5, 0, 0);

        repeat (400) begin
            int a;
            a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 4095))
                                             : int'($urandom_range(0, 63));
            op(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), a,
               int'($urandom_range(0, 255)), 0);
        end

        op(0, 1, DEPTH, 0, 0);
        op(1, 0, DEPTH, 'hEE, 0);
        op(0, 1, DEPTH - 1, 0, 0);
        op(0, 1, 0, 0, 0);

        op(1, 0, 1, 'h66, 1);
        op(1, 0, 0, 'h77, 0);
        op(0, 1, 0, 0, 0);
        op(0, 1, 1, 0, 0);
        op(1, 1, 3500, 'h12, 0);
        op(1, 1, 7, 'h34, 1);

        do_reset();
        wait_ready(ReadyLat);
`ifdef PROG_ROM_CLEAR_EN
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
`endif
        for (int a = 0; a < 8; a++) op(0, 1, a, 0, 0);
        op(0, 1, DEPTH - 1, 0, 0);
        op(1, 0, 2, 'h99, 0);
        op(0, 1, 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
